// File: rtl/hpm_counter_unit.sv
// Machine/user performance counter block: mcycle, minstret and NUM_HPM event counters
// with a single-cycle registered CSR access port and sticky overflow interrupts.
module hpm_counter_unit #(
    parameter int NUM_HPM    = 4,
    parameter int COUNTER_W  = 64,
    parameter int NUM_EVENTS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csr_valid,
    input  logic [11:0]           csr_addr,
    input  logic [1:0]            csr_op,
    input  logic [31:0]           csr_wdata,
    input  logic [1:0]            priv,
    input  logic                  instret_inc,
    input  logic [NUM_EVENTS-1:0] events,
    output logic                  csr_done,
    output logic [31:0]           csr_rdata,
    output logic                  csr_illegal,
    output logic                  overflow_irq
);

    // Counter slots are indexed by CSR number: 0 mcycle, 1 unused (time), 2 minstret, 3+ hpm.
    localparam int NUM_CNT = NUM_HPM + 3;
    localparam int SEL_W   = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
    localparam logic [31:0] INH_MASK = ((32'h1 << NUM_CNT) - 32'h1) & ~32'h2;

    function automatic logic [31:0] csr_alu(input logic [1:0] op, input logic [31:0] old_v,
                                            input logic [31:0] wd);
        case (op)
            2'b01:   csr_alu = wd;
            2'b10:   csr_alu = old_v | wd;
            2'b11:   csr_alu = old_v & ~wd;
            default: csr_alu = old_v;
        endcase
    endfunction

    logic [COUNTER_W-1:0] r_cnt [NUM_CNT];
    logic [31:0]          r_inhibit;
    logic [SEL_W-1:0]     r_evsel [NUM_HPM];
    logic [NUM_HPM-1:0]   r_of;
    logic [NUM_HPM-1:0]   r_ofie;
    logic                 r_armed;
    logic                 r_done;
    logic                 r_illegal;
    logic [31:0]          r_rdata;

    logic [4:0]           w_idx;
    logic                 w_hi;
    logic                 w_is_cnt;
    logic                 w_is_inh;
    logic                 w_is_evt;
    logic                 w_illegal;
    logic                 w_req;
    logic                 w_wr;
    logic [63:0]          w_cnt_sel;
    logic [63:0]          w_cnt_wdata;
    logic [31:0]          w_evt_sel;
    logic [31:0]          w_rdata;
    logic [31:0]          w_new;
    logic [NUM_CNT-1:0]   w_inc;
    logic [NUM_CNT-1:0]   w_cnt_wr;
    logic [NUM_HPM-1:0]   w_ovf;

    // Address decode and legality of the current request.
    always_comb begin
        w_idx    = csr_addr[4:0];
        w_hi     = csr_addr[7];
        w_is_cnt = ((csr_addr[11:8] == 4'hB) || (csr_addr[11:8] == 4'hC)) &&
                   (csr_addr[6:5] == 2'b00) &&
                   ((w_idx == 5'd0) || (w_idx == 5'd2) ||
                    ((w_idx >= 5'd3) && (32'(w_idx) < NUM_CNT)));
        w_is_inh = (csr_addr == 12'h320);
        w_is_evt = (csr_addr[11:5] == 7'h19) && (w_idx >= 5'd3) && (32'(w_idx) < NUM_CNT);
        w_illegal = ~(w_is_cnt | w_is_inh | w_is_evt) ||
                    (csr_addr[9:8] > priv) ||
                    ((csr_addr[11:10] == 2'b11) &&
                     ((csr_op == 2'b01) || (csr_op[1] && (csr_wdata != 32'h0))));
        w_req = csr_valid & r_armed;
        // Read-only space never writes, so a zero set/clear there cannot steal an increment.
        w_wr  = w_req & ~w_illegal & (csr_op != 2'b00) & (csr_addr[11:10] != 2'b11);
    end

    // Read mux and read-modify-write operand.
    always_comb begin
        w_cnt_sel = 64'h0;
        for (int k = 0; k < NUM_CNT; k++) begin
            w_cnt_sel = w_cnt_sel | ((w_idx == 5'(k)) ? 64'(r_cnt[k]) : 64'h0);
        end
        w_evt_sel = 32'h0;
        for (int j = 0; j < NUM_HPM; j++) begin
            w_evt_sel = w_evt_sel |
                        ((w_idx == 5'(j + 3)) ? {r_of[j], r_ofie[j], 30'(r_evsel[j])} : 32'h0);
        end
        if (w_is_cnt) begin
            w_rdata = w_hi ? w_cnt_sel[63:32] : w_cnt_sel[31:0];
        end else if (w_is_inh) begin
            w_rdata = r_inhibit;
        end else if (w_is_evt) begin
            w_rdata = w_evt_sel;
        end else begin
            w_rdata = 32'h0;
        end
        w_new       = csr_alu(csr_op, w_rdata, csr_wdata);
        w_cnt_wdata = w_cnt_sel;
        if (w_hi) begin
            w_cnt_wdata[63:32] = w_new;
        end else begin
            w_cnt_wdata[31:0] = w_new;
        end
    end

    // Per-counter increment, CSR-write and overflow qualifiers.
    always_comb begin
        w_inc    = '0;
        w_inc[0] = ~r_inhibit[0];
        w_inc[2] = instret_inc & ~r_inhibit[2];
        for (int j = 0; j < NUM_HPM; j++) begin
            w_inc[j + 3] = (32'(r_evsel[j]) < NUM_EVENTS) ?
                           (events[r_evsel[j]] & ~r_inhibit[j + 3]) : 1'b0;
        end
        for (int k = 0; k < NUM_CNT; k++) begin
            w_cnt_wr[k] = w_wr & w_is_cnt & (w_idx == 5'(k));
        end
        for (int j = 0; j < NUM_HPM; j++) begin
            w_ovf[j] = w_inc[j + 3] & ~w_cnt_wr[j + 3] & (&r_cnt[j + 3]);
        end
    end

    // Counter, inhibit and event-configuration state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CNT; k++) begin
                r_cnt[k] <= '0;
            end
            for (int j = 0; j < NUM_HPM; j++) begin
                r_evsel[j] <= '0;
            end
            r_inhibit <= 32'h0;
            r_of      <= '0;
            r_ofie    <= '0;
        end else begin
            for (int k = 0; k < NUM_CNT; k++) begin
                if (w_cnt_wr[k]) begin
                    r_cnt[k] <= w_cnt_wdata[COUNTER_W-1:0];
                end else if (w_inc[k]) begin
                    r_cnt[k] <= r_cnt[k] + COUNTER_W'(1);
                end else begin
                    r_cnt[k] <= r_cnt[k];
                end
            end
            // A wrap in the same cycle wins over a CSR clear of OF.
            for (int j = 0; j < NUM_HPM; j++) begin
                if (w_wr && w_is_evt && (w_idx == 5'(j + 3))) begin
                    r_evsel[j] <= w_new[SEL_W-1:0];
                    r_ofie[j]  <= w_new[30];
                    r_of[j]    <= w_new[31] | w_ovf[j];
                end else begin
                    r_of[j] <= r_of[j] | w_ovf[j];
                end
            end
            if (w_wr && w_is_inh) begin
                r_inhibit <= w_new & INH_MASK;
            end else begin
                r_inhibit <= r_inhibit;
            end
        end
    end

    // Registered response; r_armed drops any request seen on the first edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed   <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_rdata   <= 32'h0;
        end else begin
            r_armed   <= 1'b1;
            r_done    <= w_req;
            r_illegal <= w_req & w_illegal;
            r_rdata   <= (w_req && !w_illegal) ? w_rdata : 32'h0;
        end
    end

    assign csr_done     = r_done;
    assign csr_illegal  = r_illegal;
    assign csr_rdata    = r_rdata;
    assign overflow_irq = |(r_of & r_ofie);

endmodule

// File: tb/tb_hpm_counter_unit.sv
// Directed bench for hpm_counter_unit (default parameters): CSR access, counting,
// overflow, inhibit, privilege and reset behaviour against hand-computed values.
module tb_hpm_counter_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_valid = 1'b0;
    logic [11:0] csr_addr = 12'h000;
    logic [1:0]  csr_op = 2'b00;
    logic [31:0] csr_wdata = 32'h0;
    logic [1:0]  priv = 2'b11;
    logic        instret_inc = 1'b0;
    logic [7:0]  events = 8'h00;
    logic        csr_done;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        overflow_irq;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] rd;
    logic        ill;
    logic        dn;

    hpm_counter_unit #(.NUM_HPM(4), .COUNTER_W(64), .NUM_EVENTS(8)) dut (
        .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_addr(csr_addr),
        .csr_op(csr_op), .csr_wdata(csr_wdata), .priv(priv),
        .instret_inc(instret_inc), .events(events), .csr_done(csr_done),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .overflow_irq(overflow_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request just after an edge; capture its response 1 ns after the sampling edge.
    task automatic xfer(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
        csr_valid = 1'b1;
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = wd;
        @(posedge clk);
        #1;
        csr_valid = 1'b0;
        dn  = csr_done;
        rd  = csr_rdata;
        ill = csr_illegal;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", 64'(csr_done), 64'h0);
        check("rst_rdata", 64'(csr_rdata), 64'h0);
        check("rst_illegal", 64'(csr_illegal), 64'h0);
        check("rst_irq", 64'(overflow_irq), 64'h0);
        rst = 1'b0;
        idle(1);

        // mcycle low write and carry into the high half
        xfer(2'b01, 12'hB00, 32'hFFFF_FFFF);
        check("wr_mcycle_done", 64'(dn), 64'h1);
        check("wr_mcycle_ill", 64'(ill), 64'h0);
        check("wr_mcycle_old", 64'(rd), 64'h1);
        idle(1);
        xfer(2'b00, 12'hB80, 32'h0);
        check("mcycle_hi", 64'(rd), 64'h1);
        xfer(2'b00, 12'hB00, 32'h0);
        check("mcycle_lo", 64'(rd), 64'h1);

        // hpm3 overflow, sticky OF and interrupt
        xfer(2'b01, 12'h323, 32'h4000_0000);
        check("evt3_old", 64'(rd), 64'h0);
        xfer(2'b01, 12'hB83, 32'hFFFF_FFFF);
        xfer(2'b01, 12'hB03, 32'hFFFF_FFFF);
        check("pre_ovf_irq", 64'(overflow_irq), 64'h0);
        events = 8'h01;
        idle(1);
        events = 8'h00;
        check("ovf_irq", 64'(overflow_irq), 64'h1);
        xfer(2'b00, 12'hB03, 32'h0);
        check("ovf_cnt_lo", 64'(rd), 64'h0);
        xfer(2'b00, 12'hB83, 32'h0);
        check("ovf_cnt_hi", 64'(rd), 64'h0);
        xfer(2'b00, 12'h323, 32'h0);
        check("ovf_evt3", 64'(rd), 64'hC000_0000);
        xfer(2'b11, 12'h323, 32'h8000_0000);
        check("clr_of_old", 64'(rd), 64'hC000_0000);
        check("clr_of_irq", 64'(overflow_irq), 64'h0);
        xfer(2'b00, 12'h323, 32'h0);
        check("clr_of_evt3", 64'(rd), 64'h4000_0000);

        // write beats increment in the same cycle; other half preserved
        xfer(2'b01, 12'hB83, 32'h0000_0005);
        events = 8'h01;
        xfer(2'b01, 12'hB03, 32'h0000_0010);
        check("coll_old", 64'(rd), 64'h0);
        xfer(2'b00, 12'hB03, 32'h0);
        check("coll_first", 64'(rd), 64'h10);
        xfer(2'b00, 12'hB03, 32'h0);
        check("coll_second", 64'(rd), 64'h11);
        xfer(2'b00, 12'hB83, 32'h0);
        check("coll_hi_kept", 64'(rd), 64'h5);
        events = 8'h00;

        // inhibit mcycle and minstret, hpm3 keeps counting
        instret_inc = 1'b1;
        xfer(2'b01, 12'h320, 32'h0000_0005);
        xfer(2'b01, 12'hB80, 32'h0);
        xfer(2'b01, 12'hB00, 32'h0000_0100);
        xfer(2'b01, 12'hB82, 32'h0);
        xfer(2'b01, 12'hB02, 32'h0000_0200);
        xfer(2'b01, 12'hB83, 32'h0);
        xfer(2'b01, 12'hB03, 32'h0);
        events = 8'h01;
        idle(10);
        events = 8'h00;
        xfer(2'b00, 12'hB00, 32'h0);
        check("inh_mcycle", 64'(rd), 64'h100);
        xfer(2'b00, 12'hB02, 32'h0);
        check("inh_minstret", 64'(rd), 64'h200);
        xfer(2'b00, 12'hB03, 32'h0);
        check("inh_hpm3", 64'(rd), 64'hA);
        xfer(2'b00, 12'h320, 32'h0);
        check("inh_reg", 64'(rd), 64'h5);

        // privilege and read-only shadows (mcycle frozen at 0x100)
        priv = 2'b00;
        xfer(2'b00, 12'hB00, 32'h0);
        check("u_rd_m_ill", 64'(ill), 64'h1);
        check("u_rd_m_data", 64'(rd), 64'h0);
        xfer(2'b00, 12'hC00, 32'h0);
        check("u_rd_shadow_ill", 64'(ill), 64'h0);
        check("u_rd_shadow", 64'(rd), 64'h100);
        xfer(2'b01, 12'hC00, 32'h1);
        check("u_wr_shadow_ill", 64'(ill), 64'h1);
        check("u_wr_shadow_data", 64'(rd), 64'h0);
        xfer(2'b10, 12'hC02, 32'h0);
        check("u_set0_ill", 64'(ill), 64'h0);
        check("u_set0_data", 64'(rd), 64'h200);
        priv = 2'b01;
        xfer(2'b00, 12'h320, 32'h0);
        check("s_rd_inh_ill", 64'(ill), 64'h1);
        priv = 2'b11;
        xfer(2'b00, 12'hB01, 32'h0);
        check("unmapped_ill", 64'(ill), 64'h1);
        xfer(2'b00, 12'hB00, 32'h0);
        check("shadow_wr_nochg", 64'(rd), 64'h100);
        instret_inc = 1'b0;

        // release inhibit, mcycle resumes
        xfer(2'b01, 12'h320, 32'h0);
        xfer(2'b00, 12'hB00, 32'h0);
        check("resume_a", 64'(rd), 64'h100);
        xfer(2'b00, 12'hB00, 32'h0);
        check("resume_b", 64'(rd), 64'h101);
        xfer(2'b01, 12'h320, 32'hFFFF_FFFF);
        xfer(2'b00, 12'h320, 32'h0);
        check("inh_mask", 64'(rd), 64'h7D);
        xfer(2'b01, 12'h320, 32'h0);

        // mhpmevent field masking, OF via write
        xfer(2'b01, 12'h324, 32'hFFFF_FFFF);
        xfer(2'b00, 12'h324, 32'h0);
        check("evt4_mask", 64'(rd), 64'hC000_0007);
        check("evt4_irq", 64'(overflow_irq), 64'h1);

        // reset while a write is pending
        csr_valid = 1'b1;
        csr_op    = 2'b01;
        csr_addr  = 12'hB00;
        csr_wdata = 32'h0000_1234;
        #3;
        rst = 1'b1;
        #2;
        check("mrst_done", 64'(csr_done), 64'h0);
        check("mrst_irq", 64'(overflow_irq), 64'h0);
        check("mrst_rdata", 64'(csr_rdata), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_first_done", 64'(csr_done), 64'h0);
        csr_valid = 1'b0;
        xfer(2'b00, 12'hB00, 32'h0);
        check("mrst_mcycle", 64'(rd), 64'h1);
        xfer(2'b00, 12'hB80, 32'h0);
        check("mrst_mcycle_hi", 64'(rd), 64'h0);
        xfer(2'b00, 12'h324, 32'h0);
        check("mrst_evt4", 64'(rd), 64'h0);
        xfer(2'b00, 12'hB03, 32'h0);
        check("mrst_hpm3", 64'(rd), 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hpm_counter_unit.md
HPM_COUNTER_UNIT -- requirements
Module: hpm_counter_unit

Interface
REQ-001 SHALL have parameter NUM_HPM, default 4, meaning the number of mhpmcounter3.. counters implemented (1..29).
REQ-002 SHALL have parameter COUNTER_W, default 64, meaning the width of every counter (32..64).
REQ-003 SHALL have parameter NUM_EVENTS, default 8, meaning the width of the event input bus (1..256).
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1, reset (asynchronous, active-high).
REQ-006 SHALL have port csr_valid, input, 1, CSR access request.
REQ-007 SHALL have port csr_addr, input, 12, CSR address (rw_bits[11:10], privilege[9:8], sub_addr[7:0]).
REQ-008 SHALL have port csr_op, input, 2, access operation: 00 read, 01 write, 10 set, 11 clear.
REQ-009 SHALL have port csr_wdata, input, 32, write/set/clear operand.
REQ-010 SHALL have port priv, input, 2, current privilege (00 user, 01 supervisor, 11 machine).
REQ-011 SHALL have port instret_inc, input, 1, one instruction retired this cycle.
REQ-012 SHALL have port events, input, NUM_EVENTS, per-cycle single-bit event pulses.
REQ-013 SHALL have port csr_done, output, 1, response valid.
REQ-014 SHALL have port csr_rdata, output, 32, read data (pre-update value).
REQ-015 SHALL have port csr_illegal, output, 1, access rejected, no state changed.
REQ-016 SHALL have port overflow_irq, output, 1, OR of all enabled counter overflow flags.

Function
REQ-017 SHALL map addresses as follows:
- mcycle: 0xB00; minstret: 0xB02; mhpmcounter(3+i): 0xB03+i.
- High halves of each counter: address + 0x80.
- mcountinhibit: 0x320; mhpmevent(3+i): 0x323+i.
- Read-only user shadows: 0xC00, 0xC02, 0xC03+i, each with its +0x80 high half.
REQ-018 SHALL treat mhpmevent as follows:
- bits [log2(NUM_EVENTS)-1:0]: event select.
- bit 31: OF, sticky overflow flag.
- bit 30: OFIE, overflow interrupt enable.
- all other bits read 0.
- a select value >= NUM_EVENTS counts nothing.
REQ-019 SHALL use a single-cycle registered response:
- a request sampled at rising edge N produces csr_done=1 in cycle N+1, with csr_rdata/csr_illegal valid in that cycle.
- back-to-back requests are accepted every cycle; there is no ready signal.
REQ-020 SHALL apply the write effect at edge N; csr_rdata SHALL return the value before the write.
REQ-021 SHALL compute the new value as wdata (write), old|wdata (set) or old&~wdata (clear), restricted to writable bits.
REQ-022 SHALL raise csr_illegal for:
- an unmapped address;
- csr_addr[9:8] > priv;
- a write, or a set/clear with wdata!=0, to an address with csr_addr[11:10]=11.
An illegal access returns rdata=0.
REQ-023 SHALL treat set/clear with wdata=0 to a read-only address as a legal read.
REQ-024 SHALL increment counters each cycle, unless inhibited by mcountinhibit:
- mcycle by 1 (inhibit bit 0);
- minstret when instret_inc=1 (inhibit bit 2);
- mhpmcounter(3+i) when events[select] is 1 (inhibit bit 3+i).
REQ-025 SHALL hardwire mcountinhibit bit 1 and bits for unimplemented counters to 0.
REQ-026 SHALL wrap counters modulo 2^COUNTER_W.
REQ-027 SHALL set OF when an mhpmcounter wraps from all-ones to 0; OF SHALL remain set until cleared by CSR. mcycle/minstret have no OF.
REQ-028 SHALL give a CSR write to a counter half precedence over that counter's increment in the same cycle: the written value is loaded, no increment that cycle, and the other half is kept.
REQ-029 SHALL give the overflow set precedence over a simultaneous CSR clear of OF.
REQ-030 SHALL read high-half bits at or above COUNTER_W as 0; when COUNTER_W=32, high halves SHALL read 0 and ignore writes.
REQ-031 SHALL drive overflow_irq combinationally as the OR over i of (OF_i & OFIE_i).

Reset
REQ-032 SHALL, on rst assertion, immediately clear:
- all counters, mcountinhibit and every mhpmevent;
- csr_done, csr_rdata, csr_illegal and overflow_irq.
REQ-033 SHALL discard any request in flight at reset; csr_done SHALL stay 0 on the first edge after rst deasserts.

Verification
REQ-034 SHALL cover write mcycle: write 0xB00=0xFFFFFFFF, then read 0xB80 two cycles later -> high half=1 (low wrapped), rdata of the write=old value.
REQ-035 SHALL cover overflow: mhpmevent3 = select 0 | OFIE, mhpmcounter3 written all-ones on both halves, events[0]=1 one cycle -> counter=0, OF=1, overflow_irq=1; clear bit 31 -> overflow_irq=0.
REQ-036 SHALL cover inhibit: set mcountinhibit=0x5 for 10 cycles -> mcycle and minstret unchanged; mhpmcounter3 keeps counting events.
REQ-037 SHALL cover privilege: priv=00, read 0xB00 -> csr_illegal=1, rdata=0; read 0xC00 -> legal, equals mcycle; write 0xC00 with wdata=1 -> illegal, no change.
REQ-038 SHALL cover write collision: write mhpmcounter3 low=0x10 while events[select]=1 -> value 0x10 next cycle, then 0x11.
REQ-039 SHALL cover mid-operation reset: rst pulsed during a pending write -> all counters 0, csr_done=0, no write applied.
